// File: rtl/multdiv_issue_ctrl.sv
// multdiv_issue_ctrl: accepts one MULT/DIV from execute, holds operands and
// ctrl stable for the whole multdiv run, then issues a one-cycle writeback.
// Handles divide-by-zero locally, flush mid-run and a hung-unit timeout.
module multdiv_issue_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 40,
    parameter int unsigned CNT_WIDTH      = 6
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_issue_valid,
    output logic        o_issue_ready,
    input  logic        i_issue_is_div,
    input  logic [31:0] i_issue_operandA,
    input  logic [15:0] i_issue_operandB,
    input  logic [4:0]  i_issue_rd,
    input  logic        i_flush,
    output logic        o_busy,
    output logic [31:0] o_md_operandA,
    output logic [15:0] o_md_operandB,
    output logic        o_md_ctrl_MULT,
    output logic        o_md_ctrl_DIV,
    input  logic [31:0] i_md_result,
    input  logic        i_md_exception,
    input  logic        i_md_resultRDY,
    output logic        o_wb_valid,
    output logic [4:0]  o_wb_rd,
    output logic [31:0] o_wb_data,
    output logic        o_wb_exception
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [31:0]            r_opA;
    logic [15:0]            r_opB;
    logic [4:0]             r_rd;
    logic                   r_is_div;
    logic [CNT_WIDTH-1:0]   r_cnt;
    logic                   r_wb_valid;
    logic [4:0]             r_wb_rd;
    logic [31:0]            r_wb_data;
    logic                   r_wb_exception;

    logic                   w_accept;
    logic                   w_div0;
    logic                   w_cnt_last;
    logic                   w_run_live;
    logic                   w_md_exc_q;

    assign w_accept   = (r_state == S_IDLE) && i_issue_valid;
    assign w_div0     = i_issue_is_div && (i_issue_operandB == '0);
    assign w_cnt_last = (r_cnt == CNT_WIDTH'(TIMEOUT_CYCLES - 1));
    // RUN cycle that is not being flushed; the only window where md_* is sampled
    assign w_run_live = (r_state == S_RUN) && !i_flush;
    // multdiv flags zero products as overflow on MULT, so mask those
    assign w_md_exc_q = r_is_div ? i_md_exception
                                 : (i_md_exception && (r_opA != '0) && (r_opB != '0));

    // State register
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic: flush beats resultRDY beats timeout
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (i_issue_valid) begin
                    w_next = w_div0 ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (i_flush || i_md_resultRDY || w_cnt_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Outputs decoded from state; ctrl drops asynchronously with reset
    always_comb begin
        o_issue_ready  = (r_state == S_IDLE);
        o_busy         = (r_state != S_IDLE);
        o_md_ctrl_MULT = (r_state == S_RUN) && !r_is_div;
        o_md_ctrl_DIV  = (r_state == S_RUN) && r_is_div;
    end

    // Operand/destination latch and RUN-cycle counter
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_opA    <= '0;
            r_opB    <= '0;
            r_rd     <= '0;
            r_is_div <= 1'b0;
            r_cnt    <= '0;
        end else if (w_accept) begin
            r_opA    <= i_issue_operandA;
            r_opB    <= i_issue_operandB;
            r_rd     <= i_issue_rd;
            r_is_div <= i_issue_is_div;
            r_cnt    <= '0;
        end else if (r_state == S_RUN) begin
            r_cnt    <= r_cnt + 1'b1;
        end
    end

    // Writeback registers, loaded only on entry to DONE; a flushed DONE
    // leaves them untouched and keeps wb_valid low, which stands in for a kill flag
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_wb_valid     <= 1'b0;
            r_wb_rd        <= '0;
            r_wb_data      <= '0;
            r_wb_exception <= 1'b0;
        end else begin
            r_wb_valid <= 1'b0;
            if (w_accept && w_div0) begin
                r_wb_valid     <= 1'b1;
                r_wb_rd        <= i_issue_rd;
                r_wb_data      <= '0;
                r_wb_exception <= 1'b1;
            end else if (w_run_live && i_md_resultRDY) begin
                r_wb_valid     <= 1'b1;
                r_wb_rd        <= r_rd;
                r_wb_data      <= i_md_result;
                r_wb_exception <= w_md_exc_q;
            end else if (w_run_live && w_cnt_last) begin
                r_wb_valid     <= 1'b1;
                r_wb_rd        <= r_rd;
                r_wb_data      <= '0;
                r_wb_exception <= 1'b1;
            end
        end
    end

    assign o_md_operandA  = r_opA;
    assign o_md_operandB  = r_opB;
    assign o_wb_valid     = r_wb_valid;
    assign o_wb_rd        = r_wb_rd;
    assign o_wb_data      = r_wb_data;
    assign o_wb_exception = r_wb_exception;

endmodule

// File: tb/tb_multdiv_issue_ctrl.sv
// Scoreboard bench for multdiv_issue_ctrl with a behavioural multdiv model.
module tb_multdiv_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid;
    logic        issue_ready;
    logic        issue_is_div;
    logic [31:0] issue_operandA;
    logic [15:0] issue_operandB;
    logic [4:0]  issue_rd;
    logic        flush;
    logic        busy;
    logic [31:0] md_operandA;
    logic [15:0] md_operandB;
    logic        md_ctrl_MULT;
    logic        md_ctrl_DIV;
    logic [31:0] md_result;
    logic        md_exception;
    logic        md_resultRDY;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_exception;

    multdiv_issue_ctrl #(.TIMEOUT_CYCLES(40), .CNT_WIDTH(6)) dut (
        .i_clock(clk), .i_reset(rst),
        .i_issue_valid(issue_valid), .o_issue_ready(issue_ready),
        .i_issue_is_div(issue_is_div), .i_issue_operandA(issue_operandA),
        .i_issue_operandB(issue_operandB), .i_issue_rd(issue_rd),
        .i_flush(flush), .o_busy(busy),
        .o_md_operandA(md_operandA), .o_md_operandB(md_operandB),
        .o_md_ctrl_MULT(md_ctrl_MULT), .o_md_ctrl_DIV(md_ctrl_DIV),
        .i_md_result(md_result), .i_md_exception(md_exception),
        .i_md_resultRDY(md_resultRDY),
        .o_wb_valid(wb_valid), .o_wb_rd(wb_rd), .o_wb_data(wb_data),
        .o_wb_exception(wb_exception)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural multdiv unit ----------------
    bit hang = 1'b0;
    bit force_exc = 1'b0;
    int ucnt = 0;
    logic ctrl_any;
    logic u_rdy;
    logic [32:0] u_out;

    function automatic logic [32:0] unit_calc(input logic div, input logic [31:0] a, input logic [15:0] b);
        longint sa, sb, r;
        logic ovf;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ovf = 1'b0;
        if (div) begin
            r = (sb == 0) ? 64'sd0 : sa / sb;
        end else begin
            r = sa * sb;
            ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648);
        end
        return {ovf, r[31:0]};
    endfunction

    assign ctrl_any     = md_ctrl_MULT | md_ctrl_DIV;
    assign u_out        = unit_calc(md_ctrl_DIV, md_operandA, md_operandB);
    assign u_rdy        = !hang && ((md_ctrl_MULT && ucnt == 7) || (md_ctrl_DIV && ucnt == 33));
    assign md_result    = ctrl_any ? u_out[31:0] : 'z;
    assign md_exception = ctrl_any ? (u_out[32] | force_exc) : 1'bz;
    assign md_resultRDY = ctrl_any ? u_rdy : 1'bz;

    always @(posedge clk) ucnt <= ctrl_any ? ucnt + 1 : 0;

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        logic        exc;
        int          cyc;
    } wb_t;

    wb_t wbq[$];
    int  ctrlq[$];

    // Monitor: checks writebacks and the length of every ctrl-high run
    int run_len = 0;
    always @(negedge clk) begin
        if (md_ctrl_MULT && md_ctrl_DIV) check("ctrl_onehot", 32'd1, 32'd0);
        if (ctrl_any) begin
            run_len++;
        end else if (run_len > 0) begin
            if (ctrlq.size() == 0) check("ctrl_run_unexpected", run_len, 32'd0);
            else check("ctrl_run_len", run_len, ctrlq.pop_front());
            run_len = 0;
        end
        if (wb_valid === 1'b1) begin
            if (wbq.size() == 0) begin
                check("wb_unexpected", 32'd1, 32'd0);
            end else begin
                wb_t e;
                e = wbq.pop_front();
                check("wb_cycle", cyc, e.cyc);
                check("wb_rd", {27'd0, wb_rd}, {27'd0, e.rd});
                check("wb_data", wb_data, e.data);
                check("wb_exception", {31'd0, wb_exception}, {31'd0, e.exc});
            end
        end
    end

    // Reference: expected writeback and ctrl run length from the operation rules
    task automatic issue(input logic isdiv, input logic [31:0] a, input logic [15:0] b,
                         input logic [4:0] rd, input bit no_wb, input int run_ovr,
                         output int acc);
        wb_t e;
        longint sa, sb, q;
        int lat, run;
        bit ok;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        e.rd = rd;
        if (isdiv && b == 16'd0) begin
            e.data = 32'd0; e.exc = 1'b1; lat = 1; run = 0;
        end else if (hang) begin
            e.data = 32'd0; e.exc = 1'b1; lat = 41; run = 40;
        end else if (isdiv) begin
            q = sa / sb;
            e.data = q[31:0]; e.exc = 1'b0; lat = 35; run = 34;
        end else begin
            q = sa * sb;
            e.data = q[31:0];
            e.exc = (q != longint'($signed(q[31:0]))) && (a != 0) && (b != 0);
            lat = 9; run = 8;
        end
        if (run_ovr >= 0) run = run_ovr;
        @(posedge clk); #1;
        issue_valid = 1'b1; issue_is_div = isdiv;
        issue_operandA = a; issue_operandB = b; issue_rd = rd;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (issue_ready) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            check("issue_accept_timeout", 32'd0, 32'd1);
            issue_valid = 1'b0;
            acc = cyc;
            return;
        end
        @(posedge clk); #1;
        acc = cyc;
        issue_valid = 1'b0;
        issue_operandA = $urandom; issue_operandB = 16'($urandom);
        e.cyc = acc + lat - 1;
        if (!no_wb) wbq.push_back(e);
        if (run > 0) ctrlq.push_back(run);
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && (wbq.size() != 0 || ctrlq.size() != 0 || busy); i++) @(posedge clk);
        #1;
        check("drain_wbq_empty", wbq.size(), 32'd0);
        check("drain_ctrlq_empty", ctrlq.size(), 32'd0);
    endtask

    task automatic check_reset_values();
        check("rst_issue_ready", {31'd0, issue_ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_ctrl", {30'd0, md_ctrl_MULT, md_ctrl_DIV}, 32'd0);
        check("rst_opA", md_operandA, 32'd0);
        check("rst_opB", {16'd0, md_operandB}, 32'd0);
        check("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        check("rst_wb_exc", {31'd0, wb_exception}, 32'd0);
        check("rst_wb_data", wb_data, 32'd0);
        check("rst_wb_rd", {27'd0, wb_rd}, 32'd0);
    endtask

    int a1, a2;
    initial begin
        rst = 1'b1; issue_valid = 1'b0; issue_is_div = 1'b0;
        issue_operandA = '0; issue_operandB = '0; issue_rd = '0; flush = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_values();
        @(posedge clk); #1 rst = 1'b0;

        // Directed cases
        issue(1'b0, 32'd7, 16'hFFFD, 5'd5, 1'b0, -1, a1);
        drain();
        issue(1'b1, 32'd100, 16'hFFF9, 5'd9, 1'b0, -1, a1);
        drain();
        issue(1'b1, 32'd5, 16'h0000, 5'd3, 1'b0, -1, a1);
        drain();
        force_exc = 1'b1;
        issue(1'b0, 32'hFFFFFFFB, 16'h0000, 5'd4, 1'b0, -1, a1);
        drain();
        force_exc = 1'b0;

        // Back-to-back: overflow MULT then an immediately pending MULT
        issue(1'b0, 32'h40000000, 16'd4, 5'd6, 1'b0, -1, a1);
        issue(1'b0, 32'd3, 16'd5, 5'd7, 1'b0, -1, a2);
        check("b2b_accept_gap", a2 - a1, 32'd10);
        drain();

        // Flush in DIV RUN cycle 10
        issue(1'b1, 32'd1000, 16'd7, 5'd8, 1'b1, 10, a1);
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        @(negedge clk);
        check("flush_ready_c11", {31'd0, issue_ready}, 32'd0);
        @(negedge clk);
        check("flush_ready_c12", {31'd0, issue_ready}, 32'd1);
        drain();

        // Flush colliding with resultRDY in MULT RUN cycle 8: flush wins
        issue(1'b0, 32'd11, 16'd13, 5'd10, 1'b1, 8, a1);
        repeat (7) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        drain();

        // Reset in MULT RUN cycle 4
        issue(1'b0, 32'd21, 16'd2, 5'd11, 1'b1, 3, a1);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        #1 check("rst_mid_ctrl_mult", {31'd0, md_ctrl_MULT}, 32'd0);
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_values();
        @(posedge clk); #1 rst = 1'b0;
        drain();

        // Hung unit: timeout writeback
        hang = 1'b1;
        issue(1'b0, 32'd9, 16'd9, 5'd12, 1'b0, -1, a1);
        drain();
        hang = 1'b0;

        // Randomized operations
        for (int n = 0; n < 24; n++) begin
            logic        d;
            logic [31:0] a;
            logic [15:0] b;
            d = 1'($urandom);
            a = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            b = ($urandom_range(0, 5) == 0) ? 16'd0 : 16'($urandom);
            if (d && a == 32'h80000000 && b == 16'hFFFF) b = 16'd3;
            issue(d, a, b, 5'($urandom), 1'b0, -1, a1);
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
